z80_mem_window: RTL
===================

# z80_mem_window

Parametrised Z80 bus memory responder: decodes up to NUM_WIN address windows on the Z80 memory bus and serves reads and writes from the internal synchronous SRAM. Synchronises the asynchronous bus strobes into the fabric clock and inserts a programmable number of wait states. Supports per-window write protection. Sits between the Z80 socket pins (through the SB_IO data pads) and the SRAM, as the successor to the fixed single-window overlay logic.

## Interface

**Parameters**
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- NUM_WIN, 2, number of windows (1..8).
- WIN_BASE, {16'h0100, 16'h0000}, packed NUM_WIN*ADDR_W inclusive bases; window i is at slice i.
- WIN_LIMIT, {17'h0A000, 17'h00000}, packed NUM_WIN*(ADDR_W+1) exclusive limits. A limit of 0 disables the window.
- WIN_RO, 2'b00, per-window write-protect mask.
- WAIT_CYCLES, 2, minimum clk cycles that rwait is held low after detect (0..255).

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, in, 1, internal oscillator clock.
  - rst, in, 1, asynchronous active-high reset.
- Z80 bus inputs:
  - address, in, ADDR_W, Z80 address bus.
  - rd, in, 1, Z80 /RD, active-low.
  - wr, in, 1, Z80 /WR, active-low.
  - mreq, in, 1, Z80 /MREQ, active-low.
  - ioreq, in, 1, Z80 /IORQ, active-low.
  - bwait, in, 1, board /WAIT from other devices, active-low.
- Data pads and wait output:
  - data_in, in, DATA_W, pad input from the SB_IO.
  - data_out, out, DATA_W, pad output value.
  - data_oe, out, 1, pad output enable.
  - rwait, out, 1, /WAIT to the CPU, active-low.
- Bus buffer control:
  - busenable, out, 1, high while a window access is in progress.
  - dataoutenable, out, 1, equal to !busenable.
- SRAM side:
  - ram_addr, out, ADDR_W, SRAM address.
  - ram_wdata, out, DATA_W, SRAM write data.
  - ram_rdata, in, DATA_W, SRAM read data, valid 1 clk after ram_cs.
  - ram_cs, out, 1, SRAM select pulse.
  - ram_we, out, 1, SRAM write strobe.
- Status:
  - win_idx, out, 3, index of the last window hit.
  - ro_violation, out, 1, 1-clk pulse on a write to a protected window.

## Operation

**Synchroniser**
- rd, wr and mreq pass through 2-flop synchronisers.
- Access request: req = !mreq_s & (!rd_s ^ !wr_s) & ioreq.
- rd and wr both low is treated as not a request.

**Window decode**
- Hit i when WIN_BASE[i] <= address < WIN_LIMIT[i], compared at ADDR_W+1 bits.
- When windows overlap, the lowest index wins.

**FSM states:** IDLE, RD_REQ, RD_DATA, WR_DO, HOLD, MISS.

- **IDLE**, on req:
  - Register address into ram_addr, data_in into ram_wdata, and the hit index into win_idx.
  - No hit → MISS.
  - Read hit → RD_REQ.
  - Write hit → WR_DO.
  - On a hit with WAIT_CYCLES>0: assert the wait request and load wcnt=WAIT_CYCLES.
- **RD_REQ**: ram_cs=1, ram_we=0 → RD_DATA.
- **RD_DATA**: capture ram_rdata into data_out, set drive_q=1 → HOLD.
- **WR_DO**:
  - ram_cs=1, ram_we=!WIN_RO[win_idx].
  - If the window is protected: ro_violation=1 for this cycle.
  - → HOLD.
- **HOLD**: when the synchronised strobe returns high → IDLE; clear drive_q.
- **MISS**: no outputs driven; when the strobe releases → IDLE.

**Wait counter and release**
- wcnt decrements each clk while non-zero.
- The wait request clears when wcnt==0 and the access is complete (drive_q=1 for reads; HOLD reached for writes).

**Output equations**
- rwait = bwait & !wait_req.
- data_oe = drive_q & !rd. Raw rd gates the output combinationally, so the pads release immediately when /RD rises, with no synchroniser delay.
- busenable = state in {RD_REQ, RD_DATA, WR_DO} or (state==HOLD and the access was a hit).

## Timing

**Reset values**
- Reset is asynchronous and takes effect immediately, including mid-access; the FSM returns to IDLE.
- data_out=0, data_oe=0.
- rwait follows bwait.
- busenable=0, dataoutenable=1.
- ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0.
- win_idx=0, ro_violation=0.
- Synchroniser flops reset to 1.

**Cycle sequence**, with strobe falling before edge S and detect edge E0 = S+2:
- Wait request visible on rwait from E0.
- Read: ram_cs high during E0→E1; data_out valid and data_oe high from E2.
- Write: ram_cs and ram_we high during E0→E1.
- rwait release: edge max(E0+WAIT_CYCLES, E2) for reads, and max(E0+WAIT_CYCLES, E1) for writes.
- WAIT_CYCLES=0: rwait is never asserted; read data still appears at E2.

**Boundaries**
- address = limit−1 hits; address = limit misses.
- A limit of 2^ADDR_W covers the top address.
- Exactly one ram_cs pulse per bus access, regardless of strobe length.

## Test plan

1. Reset, then read at 16'h0100 with SRAM holding 8'hA5 and WAIT_CYCLES=2 → one ram_cs pulse; data_out=8'hA5 and data_oe=1 at E2; rwait low for exactly 2 clks from E0.
2. Write 8'h3C to 16'h9FFF → ram_cs=ram_we=1 for 1 clk with ram_addr=16'h9FFF and ram_wdata=8'h3C. Then access 16'hA000 → MISS: no ram_cs, rwait stays high, busenable=0.
3. WIN_RO[0]=1, write to window 0 → ram_cs=1, ram_we=0, ro_violation pulses 1 clk, win_idx=0, access completes normally.
4. Read with WAIT_CYCLES=5, bwait held low externally → rwait low throughout; after bwait rises, rwait follows it once wcnt expires.
5. Assert rst at RD_DATA mid-read → data_oe=0, ram_cs=0 and rwait=bwait immediately; the next read at 16'h0100 completes normally.
6. Hold rd and wr low together, and separately assert an /IORQ cycle at 16'h0200 → no ram_cs, FSM stays IDLE.

Source files
------------

// File: rtl/z80_mem_window.sv
// Z80 memory-bus responder: decodes address windows and serves
// synchronised reads/writes from an internal SRAM with wait states.
module z80_mem_window #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NUM_WIN = 2,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE =
    {16'h0100, 16'h0000},
  parameter logic [NUM_WIN*(ADDR_W+1)-1:0] WIN_LIMIT =
    {17'h0A000, 17'h00000},
  parameter logic [NUM_WIN-1:0] WIN_RO = 2'b00,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd,
  input  logic              wr,
  input  logic              mreq,
  input  logic              ioreq,
  input  logic              bwait,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              rwait,
  output logic              busenable,
  output logic              dataoutenable,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [2:0]        win_idx,
  output logic              ro_violation
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DO,
    HOLD,
    MISS
  } state_t;

  localparam logic [7:0] RO_PAD = 8'(WIN_RO);
  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

  state_t      state;
  logic [1:0]  rd_sync;
  logic [1:0]  wr_sync;
  logic [1:0]  mreq_sync;
  logic        rd_s;
  logic        wr_s;
  logic        mreq_s;
  logic        req;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        is_rd;
  logic        drive_q;
  logic        wait_req;
  logic [7:0]  wcnt;
  logic        strobe_up;
  logic        done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sync   <= 2'b11;
      wr_sync   <= 2'b11;
      mreq_sync <= 2'b11;
    end else begin
      rd_sync   <= {rd_sync[0], rd};
      wr_sync   <= {wr_sync[0], wr};
      mreq_sync <= {mreq_sync[0], mreq};
    end
  end

  assign rd_s   = rd_sync[1];
  assign wr_s   = wr_sync[1];
  assign mreq_s = mreq_sync[1];

  // Exactly one of /RD,/WR low; both low is a bus glitch, not an access.
  assign req = !mreq_s & (!rd_s ^ !wr_s) & ioreq;

  function automatic logic in_win(input int i,
                                  input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax;
    logic [ADDR_W:0] base;
    logic [ADDR_W:0] lim;
    ax   = {1'b0, a};
    base = {1'b0, WIN_BASE[i*ADDR_W +: ADDR_W]};
    lim  = WIN_LIMIT[i*(ADDR_W+1) +: ADDR_W+1];
    return (ax >= base) && (ax < lim);
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (in_win(i, address)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  assign strobe_up = is_rd ? rd_s : wr_s;

  // Access is complete once read data is captured or a write issued.
  assign done = (state == RD_DATA) || (state == WR_DO) ||
                (state == HOLD) || (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      data_out     <= '0;
      drive_q      <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      win_idx      <= 3'd0;
      ro_violation <= 1'b0;
      busenable    <= 1'b0;
      is_rd        <= 1'b0;
      wait_req     <= 1'b0;
      wcnt         <= 8'd0;
    end else begin
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ro_violation <= 1'b0;
      if (wcnt != 8'd0)
        wcnt <= wcnt - 8'd1;
      if (wait_req && (wcnt <= 8'd1) && done)
        wait_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            ram_addr  <= address;
            ram_wdata <= data_in;
            is_rd     <= !rd_s;
            if (!hit) begin
              state <= MISS;
            end else begin
              win_idx   <= hit_idx;
              busenable <= 1'b1;
              ram_cs    <= 1'b1;
              if (!rd_s) begin
                state <= RD_REQ;
              end else begin
                state        <= WR_DO;
                ram_we       <= !RO_PAD[hit_idx];
                ro_violation <= RO_PAD[hit_idx];
              end
              if (WAIT_CYCLES > 0) begin
                wait_req <= 1'b1;
                wcnt     <= WAIT_LD;
              end
            end
          end
        end
        RD_REQ: state <= RD_DATA;
        RD_DATA: begin
          data_out <= ram_rdata;
          drive_q  <= 1'b1;
          state    <= HOLD;
        end
        WR_DO: state <= HOLD;
        HOLD: begin
          if (strobe_up) begin
            state     <= IDLE;
            drive_q   <= 1'b0;
            busenable <= 1'b0;
          end
        end
        MISS: begin
          if (strobe_up)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raw /RD gates the pads so they release without synchroniser lag.
  assign data_oe       = drive_q & !rd;
  assign rwait         = bwait & !wait_req;
  assign dataoutenable = !busenable;

endmodule
